acc_fp_align: RTL

- Two-operand front end of the fp accumulator. Takes two packed 16-bit operands ({sgn, exp[3:0], man[10:0]}) and unpacks each one.
- Aligns the smaller-exponent operand to the larger exponent and forms the signed 17-bit significand sum.
- Emits exactly the {align_sgn, align_exp, align_man} bundle consumed by acc_fp_norm.
- 2-stage valid/ready pipeline with full backpressure, placed directly ahead of the normalizer.

---
 rtl/acc_fp_pkg.sv | 27 ++
 rtl/acc_fp_unpack.sv | 24 ++
 rtl/acc_fp_align.sv | 109 ++++++++++
 3 files changed

// File: rtl/acc_fp_pkg.sv
// Shared definitions for the fp accumulator datapath (acc_fp_align, acc_fp_norm).
// Packed operand layout: {sgn[15], exp[14:11], man[10:0]}.
// Aligned significand field: {carry, sig[11:0], guard[2:0]} = ALIGN_W bits.
package acc_fp_pkg;

  localparam int unsigned EXP_W   = 4;
  localparam int unsigned MAN_W   = 11;
  localparam int unsigned SIG_W   = MAN_W + 1;
  localparam int unsigned ALIGN_W = 16;
  localparam int unsigned OP_W    = 1 + EXP_W + MAN_W;
  // Low zero bits appended below the significand so small shifts keep some precision.
  localparam int unsigned GUARD_W = ALIGN_W - SIG_W - 1;

  // Packed-operand field offsets.
  localparam int unsigned SGN_POS = 15;
  localparam int unsigned EXP_MSB = 14;
  localparam int unsigned EXP_LSB = 11;
  localparam int unsigned MAN_MSB = 10;
  localparam int unsigned MAN_LSB = 0;

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] eff_exp;
    logic [SIG_W-1:0] sig;
  } fp_unpacked_t;

endpackage

// File: rtl/acc_fp_unpack.sv
// Combinational operand unpack.
//   op : packed operand {sgn, exp, man}
//   u  : {sgn, eff_exp, sig}; sig carries the hidden bit (exp!=0),
//        denormals (exp==0) use an effective exponent of 1.
module acc_fp_unpack
  import acc_fp_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output fp_unpacked_t    u
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = op[EXP_MSB:EXP_LSB];
  assign man_f = op[MAN_MSB:MAN_LSB];

  always_comb begin
    u.sgn     = op[SGN_POS];
    u.eff_exp = (exp_f == '0) ? EXP_W'(1) : exp_f;
    u.sig     = {exp_f != '0, man_f};
  end

endmodule

// File: rtl/acc_fp_align.sv
// Two-operand alignment front end of the fp accumulator.
// Stage 1 unpacks both operands, picks the larger-exponent one (op_a on a tie)
// and right-shifts the other by the exponent difference (truncating).
// Stage 2 forms the 17-bit two's-complement significand sum.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand-pair handshake (op_a, op_b)
//   out_valid/out_ready : result handshake
//   align_sgn           : [1]=effective subtract, [0]=sign of big operand
//   align_exp           : max effective exponent + 1 (wraps)
//   align_man           : signed significand sum, bit 16 is the sign
//   align_ovf           : max effective exponent was 15 (align_exp wrapped)
module acc_fp_align
  import acc_fp_pkg::*;
#(
  parameter int unsigned SHIFT_SAT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op_a,
  input  logic [OP_W-1:0]    op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         align_sgn,
  output logic [EXP_W-1:0]   align_exp,
  output logic [ALIGN_W:0]   align_man,
  output logic               align_ovf
);

  fp_unpacked_t ua, ub, big, sml;

  acc_fp_unpack u_unpack_a (.op(op_a), .u(ua));
  acc_fp_unpack u_unpack_b (.op(op_b), .u(ub));

  logic               b_wins;
  logic [EXP_W-1:0]   diff;
  logic [ALIGN_W-1:0] big16_c, small16_c;

  always_comb begin
    b_wins   = ub.eff_exp > ua.eff_exp;
    big      = b_wins ? ub : ua;
    sml      = b_wins ? ua : ub;
    diff     = big.eff_exp - sml.eff_exp;
    big16_c  = ALIGN_W'({big.sig, {GUARD_W{1'b0}}});
    if (32'(diff) >= SHIFT_SAT) small16_c = '0;
    else                        small16_c = ALIGN_W'({sml.sig, {GUARD_W{1'b0}}}) >> diff;
  end

  // Handshake: each stage loads when the stage after it is empty or draining.
  logic s1_v, s2_v, s1_en, s2_en;

  assign s2_en     = !s2_v || out_ready;
  assign s1_en     = !s1_v || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_v;

  logic [ALIGN_W-1:0] s1_big16, s1_small16;
  logic               s1_sgn_big, s1_eff_sub;
  logic [EXP_W-1:0]   s1_e_big;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s1_big16   <= '0;
      s1_small16 <= '0;
      s1_sgn_big <= 1'b0;
      s1_eff_sub <= 1'b0;
      s1_e_big   <= '0;
    end else begin
      if (s1_en) s1_v <= in_valid;
      if (in_valid && s1_en) begin
        s1_big16   <= big16_c;
        s1_small16 <= small16_c;
        s1_sgn_big <= big.sgn;
        s1_eff_sub <= ua.sgn ^ ub.sgn;
        s1_e_big   <= big.eff_exp;
      end
    end
  end

  logic [ALIGN_W:0] big_x, small_x, sum_c;

  always_comb begin
    big_x   = {1'b0, s1_big16};
    small_x = {1'b0, s1_small16};
    sum_c   = s1_eff_sub ? (big_x - small_x) : (big_x + small_x);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v      <= 1'b0;
      align_sgn <= '0;
      align_exp <= '0;
      align_man <= '0;
      align_ovf <= 1'b0;
    end else begin
      if (s2_en) s2_v <= s1_v;
      if (s1_v && s2_en) begin
        align_man <= sum_c;
        align_sgn <= {s1_eff_sub, s1_sgn_big};
        align_exp <= s1_e_big + EXP_W'(1);
        align_ovf <= (s1_e_big == '1);
      end
    end
  end

endmodule
